// File: rtl/line_buffer_pkg.sv
// Shared LC-3b memory types and line-buffer FSM encoding.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [15:0]  lc3b_pmem_addr;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [11:0]  lc3b_lb_tag;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESPOND   = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } lc3b_lb_state_t;
endpackage

// File: rtl/line_buffer_control.sv
// Line-buffer sequencer: hit/miss decision in IDLE, writeback then fetch on a miss.
module line_buffer_control
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           hit,
  input  logic           dirty,
  input  logic           pmem_resp,
  output lc3b_lb_state_t state,
  output logic           hit_evt,
  output logic           miss_evt,
  output logic           load_line,
  output logic           wb_done
);
  lc3b_lb_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    load_line = 1'b0;
    wb_done   = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (hit) begin
          hit_evt = 1'b1;
          state_d = RESPOND;
        end else begin
          miss_evt = 1'b1;
          state_d  = dirty ? WRITEBACK : FETCH;
        end
      end
      RESPOND: state_d = IDLE;
      WRITEBACK: if (pmem_resp) begin
        wb_done = 1'b1;
        state_d = FETCH;
      end
      FETCH: if (pmem_resp) begin
        load_line = 1'b1;
        state_d   = RESPOND;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;
endmodule

// File: rtl/line_buffer.sv
// Single-line write-back buffer between the CPU word port and the 128-bit line port.
// Optional hit/miss counters are enabled with LINE_BUFFER_STATS_EN.
module line_buffer
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_pmem_addr pmem_address,
  output lc3b_pmem_line pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_pmem_line pmem_rdata
`ifdef LINE_BUFFER_STATS_EN
  ,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
`endif
);
  lc3b_pmem_line  line_q, line_d;
  lc3b_lb_tag     tag_q, tag_d;
  logic           valid_q, valid_d;
  logic           dirty_q, dirty_d;
  lc3b_lb_state_t state;
  logic           hit_evt, miss_evt, load_line, wb_done;
  logic           req, is_write, hit, addr_unused;
  lc3b_lb_tag     req_tag;
  logic [6:0]     word_lsb;
  lc3b_word       cur_word, merged_word;

  assign addr_unused = mem_address[0];
  assign req         = mem_read | mem_write;
  assign is_write    = mem_write & ~mem_read;   // read wins when both are asserted
  assign req_tag     = mem_address[15:4];
  assign word_lsb    = {mem_address[3:1], 4'b0};
  assign hit         = valid_q && (tag_q == req_tag);
  assign cur_word    = line_q[word_lsb +: 16];

  line_buffer_control u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .hit       (hit),
    .dirty     (dirty_q),
    .pmem_resp (pmem_resp),
    .state     (state),
    .hit_evt   (hit_evt),
    .miss_evt  (miss_evt),
    .load_line (load_line),
    .wb_done   (wb_done)
  );

  always_comb begin
    merged_word = cur_word;
    if (mem_byte_enable[0]) merged_word[7:0]  = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_word[15:8] = mem_wdata[15:8];
  end

  always_comb begin
    line_d  = line_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wb_done) dirty_d = 1'b0;
    if (load_line) begin
      line_d  = pmem_rdata;
      tag_d   = req_tag;
      valid_d = 1'b1;
      dirty_d = 1'b0;
    end
    // Empty byte mask still completes but must not mark the line dirty.
    if (state == RESPOND && is_write && |mem_byte_enable) begin
      line_d[word_lsb +: 16] = merged_word;
      dirty_d                = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      line_q  <= line_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_comb begin
    mem_resp     = (state == RESPOND);
    mem_rdata    = (mem_resp && mem_read) ? cur_word : '0;
    pmem_read    = (state == FETCH);
    pmem_write   = (state == WRITEBACK);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (pmem_write) begin
      pmem_address = {tag_q, 4'b0};
      pmem_wdata   = line_q;
    end else if (pmem_read) begin
      pmem_address = {req_tag, 4'b0};
    end
  end

`ifdef LINE_BUFFER_STATS_EN
  logic [15:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit_evt && hit_count_q != 16'hFFFF)   hit_count_d  = hit_count_q + 16'd1;
    if (miss_evt && miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_line_buffer.sv
// Randomized bench for line_buffer against a word-array cache model and a backing-memory map.
module tb_line_buffer;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0;
  lc3b_mem_wmask mem_byte_enable = '0;
  lc3b_word      mem_address = '0, mem_wdata = '0;
  logic          mem_resp;
  lc3b_word      mem_rdata;
  logic          pmem_read, pmem_write;
  lc3b_pmem_addr pmem_address;
  lc3b_pmem_line pmem_wdata;
  logic          pmem_resp = 1'b0;
  lc3b_pmem_line pmem_rdata = '0;
`ifdef LINE_BUFFER_STATS_EN
  logic [15:0]   hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  line_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
`ifdef LINE_BUFFER_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the buffered line as eight words plus a sparse backing memory.
  bit            m_valid, m_dirty;
  logic [11:0]   m_tag;
  logic [15:0]   m_line [8];
  logic [127:0]  bmem [logic [11:0]];
  int            m_hits, m_miss;

  function automatic logic [127:0] pack_line();
    logic [127:0] v;
    for (int w = 0; w < 8; w++) v[w*16 +: 16] = m_line[w];
    return v;
  endfunction

  function automatic logic [127:0] backing(input logic [11:0] t);
    if (!bmem.exists(t)) bmem[t] = {$urandom, $urandom, $urandom, $urandom};
    return bmem[t];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_dirty = 0; m_tag = '0; m_hits = 0; m_miss = 0;
    for (int w = 0; w < 8; w++) m_line[w] = '0;
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_resp"}, mem_resp, 0);
    chk({nm, "_rdata"}, mem_rdata, 0);
    chk({nm, "_prd"}, pmem_read, 0);
    chk({nm, "_pwr"}, pmem_write, 0);
    chk({nm, "_paddr"}, pmem_address, 0);
    chk({nm, "_pwdata"}, pmem_wdata, 0);
`ifdef LINE_BUFFER_STATS_EN
    chk({nm, "_hits"}, hit_count, 0);
    chk({nm, "_miss"}, miss_count, 0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    mem_read = 0; mem_write = 0; pmem_resp = 0;
    @(posedge clk); #1 rst_n = 1;
    model_reset();
    @(negedge clk);
    check_quiet("reset");
  endtask

  // One CPU transaction; called #1 after a rising edge.
  task automatic do_req(input bit rd, input bit wr, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input string nm, output logic [15:0] got);
    logic [11:0]  t = addr[15:4];
    int           idx = int'(addr[3:1]);
    bit           exp_hit = m_valid && (m_tag == t);
    bit           exp_wb = !exp_hit && m_dirty;
    logic [127:0] wb_line = pack_line();
    logic [11:0]  old_tag = m_tag;
    logic [15:0]  exp_rd;
    logic [127:0] fill;
    int cycles = 0, pm = 0;
    bit done = 0, wb_seen = 0, fe_seen = 0, bad = 0, order_bad = 0;

    if (exp_hit) m_hits++;
    else begin
      m_miss++;
      if (exp_wb) bmem[old_tag] = wb_line;
      fill = backing(t);
      for (int w = 0; w < 8; w++) m_line[w] = fill[w*16 +: 16];
      m_tag = t; m_valid = 1; m_dirty = 0;
    end
    exp_rd = m_line[idx];
    if (wr && !rd && be != 2'b00) begin
      if (be[0]) m_line[idx][7:0]  = wdata[7:0];
      if (be[1]) m_line[idx][15:8] = wdata[15:8];
      m_dirty = 1;
    end

    mem_read = rd; mem_write = wr; mem_byte_enable = be;
    mem_address = addr; mem_wdata = wdata;
    got = '0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      pmem_resp = 0;
      cycles++;
      if (pmem_read && pmem_write) bad = 1;
      if (!mem_resp && mem_rdata != 0) bad = 1;
      if (pmem_write) begin
        pm++;
        if (!wb_seen) begin
          chk({nm, "_wb_addr"}, pmem_address, {old_tag, 4'h0});
          chk({nm, "_wb_data"}, pmem_wdata, wb_line);
          wb_seen = 1;
          if (fe_seen) order_bad = 1;
        end
        if ($urandom_range(1) == 1) pmem_resp = 1;
      end else if (pmem_read) begin
        pm++;
        if (!fe_seen) begin
          chk({nm, "_fe_addr"}, pmem_address, {t, 4'h0});
          fe_seen = 1;
        end
        if ($urandom_range(1) == 1) begin
          pmem_rdata = backing(pmem_address[15:4]);
          pmem_resp  = 1;
        end
      end else if (pmem_address != 0) bad = 1;
      if (mem_resp) begin
        done = 1;
        got = mem_rdata;
        if (rd) chk({nm, "_rdata"}, mem_rdata, exp_rd);
      end
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_wb_seen"}, wb_seen, exp_wb);
    chk({nm, "_fe_seen"}, fe_seen, !exp_hit);
    chk({nm, "_protocol"}, {bad, order_bad}, 0);
    if (exp_hit) begin
      chk({nm, "_lat"}, cycles, 2);
      chk({nm, "_nopmem"}, pm, 0);
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; pmem_resp = 0;
  endtask

  task automatic check_stats(input string nm);
`ifdef LINE_BUFFER_STATS_EN
    chk({nm, "_hit_count"}, hit_count, m_hits);
    chk({nm, "_miss_count"}, miss_count, m_miss);
`else
    if (nm.len() == 0) $display("stats disabled");
`endif
  endtask

  logic [15:0]  got;
  logic [127:0] l100;
  logic [11:0]  tags [4] = '{12'h100, 12'h200, 12'h300, 12'hABC};

  initial begin
    model_reset();
    l100 = {$urandom, $urandom, $urandom, $urandom};
    l100[31:16] = 16'hBEEF;
    bmem[12'h100] = l100;

    do_reset();

    do_req(1, 0, 2'b00, 16'h1002, 16'h0, "rd1002", got);
    chk("rd1002_beef", got, 16'hBEEF);
    do_req(0, 1, 2'b01, 16'h1006, 16'h12AB, "wr1006", got);
    do_req(1, 0, 2'b00, 16'h1006, 16'h0, "rd1006", got);
    chk("rd1006_lowbyte", got[7:0], 8'hAB);
    do_req(0, 1, 2'b00, 16'h1008, 16'hFFFF, "wr_nobe", got);
    do_req(1, 0, 2'b00, 16'h2000, 16'h0, "rd2000_wb", got);
    chk("bmem_1000_written", bmem[12'h100][63:48], {l100[63:56], 8'hAB});

    // Abandon a fetch with reset, then deliver a stale pmem_resp.
    mem_read = 1; mem_address = 16'h3000;
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (pmem_read) seen = 1;
      end
      chk("rstfetch_pmem_read", seen, 1);
    end
    @(posedge clk); #1 rst_n = 0; mem_read = 0;
    @(posedge clk); #1 rst_n = 1; model_reset();
    pmem_rdata = backing(12'h300); pmem_resp = 1;
    @(negedge clk);
    check_quiet("rstfetch_a");
    @(posedge clk); #1 pmem_resp = 0;
    @(negedge clk);
    check_quiet("rstfetch_b");
    @(posedge clk); #1;

    do_req(1, 0, 2'b00, 16'h2000, 16'h0, "rd2000_after_rst", got);
    do_req(1, 1, 2'b11, 16'h2004, 16'hFFFF, "rdwr_both", got);
    do_req(1, 0, 2'b00, 16'h2004, 16'h0, "rd2004_unchanged", got);
    do_req(1, 0, 2'b00, 16'h200E, 16'h0, "rd200e", got);
    check_stats("directed");

    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      int kind;
      a = {tags[$urandom_range(3)], 4'($urandom)};
      kind = $urandom_range(9);
      do_req(kind < 5 || kind == 9, kind >= 5, 2'($urandom), a, 16'($urandom), "rand", got);
    end
    check_stats("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
